branch_bypass_scoreboard: RTL and testbench

//  Decode-stage operand forwarding for early (fast) branch resolution, parametrised in width, depth and source count.

---
 rtl/branch_bypass_scoreboard.sv | 153 +++++++++++++++
 tb/tb_branch_bypass_scoreboard.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_bypass_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : branch_bypass_scoreboard
// Description : Decode-stage operand forwarding for early branch resolution.
//               Keeps a shifting scoreboard of in-flight destination registers
//               for the DEPTH stages after decode. For each decode source it
//               selects the youngest producer value, or stalls while the
//               youngest producer is a load whose data is not yet available.
//               Optional macro BYPASS_STATS_EN adds saturating forward/stall
//               event counters (stat_fwd_cnt, stat_stall_cnt).
// Revision    : 1.0 - initial release
// ============================================================================
module branch_bypass_scoreboard #(
    parameter int WIDTH            = 32,
    parameter int REG_BITS         = 5,
    parameter int DEPTH            = 3,
    parameter int NUM_SRC          = 2,
    parameter int LOAD_READY_STAGE = 1
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        advance,
    input  logic                        flush,
    input  logic                        issue_valid,
    input  logic                        issue_we,
    input  logic                        issue_is_load,
    input  logic [REG_BITS-1:0]         issue_rd,
    input  logic [DEPTH*WIDTH-1:0]      stage_result,
    input  logic [NUM_SRC-1:0]          src_used,
    input  logic [NUM_SRC*REG_BITS-1:0] src_reg,
    input  logic [NUM_SRC*WIDTH-1:0]    src_rf_data,
    output logic [NUM_SRC*WIDTH-1:0]    src_data,
    output logic [NUM_SRC*2-1:0]        fwd_sel,
    output logic                        hazard_stall
`ifdef BYPASS_STATS_EN
    ,
    output logic [15:0]                 stat_fwd_cnt,
    output logic [15:0]                 stat_stall_cnt
`endif
);

    localparam logic [1:0] c_SEL_RF    = 2'd0;
    localparam logic [1:0] c_SEL_FWD   = 2'd1;
    localparam logic [1:0] c_SEL_STALL = 2'd2;

    // Scoreboard: index 0 is the X stage, DEPTH-1 the oldest tracked stage.
    logic [DEPTH-1:0]    r_v;
    logic [DEPTH-1:0]    r_ld;
    logic [REG_BITS-1:0] r_rd [DEPTH];

    logic [NUM_SRC-1:0]  w_stall_vec;
    logic                w_insert;

    // A stalled decode instruction must not be recorded; its bubble goes in instead.
    assign w_insert = issue_valid && issue_we && (issue_rd != '0) && !flush && !hazard_stall;

    // Shift the scoreboard when the pipeline advances; hold otherwise.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_v  <= '0;
            r_ld <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_rd[i] <= '0;
            end
        end else if (advance) begin
            for (int i = DEPTH - 1; i >= 1; i--) begin
                r_v[i]  <= r_v[i-1];
                r_ld[i] <= r_ld[i-1];
                r_rd[i] <= r_rd[i-1];
            end
            r_v[0]  <= w_insert;
            r_ld[0] <= w_insert && issue_is_load;
            r_rd[0] <= w_insert ? issue_rd : '0;
        end
    end

    generate
        for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
            logic [REG_BITS-1:0] w_reg;
            logic [WIDTH-1:0]    w_rf;
            logic [WIDTH-1:0]    w_data;
            logic [1:0]          w_sel;
            logic                w_stall;

            assign w_reg = src_reg[s*REG_BITS +: REG_BITS];
            assign w_rf  = src_rf_data[s*WIDTH +: WIDTH];

            // Walk oldest to youngest so the youngest match has the final say.
            always_comb begin
                w_data  = w_rf;
                w_sel   = c_SEL_RF;
                w_stall = 1'b0;
                if (src_used[s] && (w_reg != '0)) begin
                    for (int i = DEPTH - 1; i >= 0; i--) begin
                        if (r_v[i] && (r_rd[i] == w_reg)) begin
                            if (r_ld[i] && (i < LOAD_READY_STAGE)) begin
                                w_data  = w_rf;
                                w_sel   = c_SEL_STALL;
                                w_stall = 1'b1;
                            end else begin
                                w_data  = stage_result[i*WIDTH +: WIDTH];
                                w_sel   = c_SEL_FWD;
                                w_stall = 1'b0;
                            end
                        end
                    end
                end
            end

            assign src_data[s*WIDTH +: WIDTH] = w_data;
            assign fwd_sel[s*2 +: 2]          = w_sel;
            assign w_stall_vec[s]             = w_stall;
        end
    endgenerate

    assign hazard_stall = |w_stall_vec;

`ifdef BYPASS_STATS_EN
    logic        w_fwd_any;
    logic [15:0] r_stat_fwd_cnt;
    logic [15:0] r_stat_stall_cnt;

    // Any source currently taking a forwarded value.
    always_comb begin
        w_fwd_any = 1'b0;
        for (int s = 0; s < NUM_SRC; s++) begin
            if (fwd_sel[s*2 +: 2] == c_SEL_FWD) begin
                w_fwd_any = 1'b1;
            end
        end
    end

    // Saturating event counters: forwards consumed by an advancing decode, and stall cycles.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_stat_fwd_cnt   <= '0;
            r_stat_stall_cnt <= '0;
        end else begin
            if (advance && !hazard_stall && w_fwd_any && (r_stat_fwd_cnt != 16'hFFFF)) begin
                r_stat_fwd_cnt <= r_stat_fwd_cnt + 16'd1;
            end
            if (hazard_stall && (r_stat_stall_cnt != 16'hFFFF)) begin
                r_stat_stall_cnt <= r_stat_stall_cnt + 16'd1;
            end
        end
    end

    assign stat_fwd_cnt   = r_stat_fwd_cnt;
    assign stat_stall_cnt = r_stat_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_branch_bypass_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_bypass_scoreboard
// Description : Self-checking bench for branch_bypass_scoreboard. Directed
//               scenarios followed by randomized traffic, all compared against
//               a queue-based model of in-flight producers.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_bypass_scoreboard;

    localparam int WIDTH    = 32;
    localparam int REG_BITS = 5;
    localparam int DEPTH    = 3;
    localparam int NUM_SRC  = 2;
    localparam int LRS      = 1;

    logic                        clock = 1'b0;
    logic                        reset = 1'b0;
    logic                        advance;
    logic                        flush;
    logic                        issue_valid;
    logic                        issue_we;
    logic                        issue_is_load;
    logic [REG_BITS-1:0]         issue_rd;
    logic [DEPTH*WIDTH-1:0]      stage_result;
    logic [NUM_SRC-1:0]          src_used;
    logic [NUM_SRC*REG_BITS-1:0] src_reg;
    logic [NUM_SRC*WIDTH-1:0]    src_rf_data;
    logic [NUM_SRC*WIDTH-1:0]    src_data;
    logic [NUM_SRC*2-1:0]        fwd_sel;
    logic                        hazard_stall;
`ifdef BYPASS_STATS_EN
    logic [15:0]                 stat_fwd_cnt;
    logic [15:0]                 stat_stall_cnt;
`endif

    branch_bypass_scoreboard #(
        .WIDTH(WIDTH), .REG_BITS(REG_BITS), .DEPTH(DEPTH),
        .NUM_SRC(NUM_SRC), .LOAD_READY_STAGE(LRS)
    ) dut (
        .clock(clock), .reset(reset), .advance(advance), .flush(flush),
        .issue_valid(issue_valid), .issue_we(issue_we),
        .issue_is_load(issue_is_load), .issue_rd(issue_rd),
        .stage_result(stage_result), .src_used(src_used), .src_reg(src_reg),
        .src_rf_data(src_rf_data), .src_data(src_data), .fwd_sel(fwd_sel),
        .hazard_stall(hazard_stall)
`ifdef BYPASS_STATS_EN
        , .stat_fwd_cnt(stat_fwd_cnt), .stat_stall_cnt(stat_stall_cnt)
`endif
    );

    always #5 clock = ~clock;

    // Model: queue of issued slots, front = most recently issued (X stage).
    typedef struct {
        bit v;
        int rd;
        bit ld;
    } slot_t;
    slot_t q[$];

    int n_checks = 0;
    int n_errors = 0;

    logic [WIDTH-1:0] exp_data [NUM_SRC];
    logic [1:0]       exp_sel  [NUM_SRC];
    logic             exp_stall;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Compute expected outputs from the model and compare right now.
    task automatic compare();
        int r;
        exp_stall = 1'b0;
        for (int s = 0; s < NUM_SRC; s++) begin
            r = int'(src_reg[s*REG_BITS +: REG_BITS]);
            exp_data[s] = src_rf_data[s*WIDTH +: WIDTH];
            exp_sel[s]  = 2'd0;
            if (src_used[s] && r != 0) begin
                for (int i = 0; i < q.size(); i++) begin
                    if (q[i].v && q[i].rd == r) begin
                        if (q[i].ld && i < LRS) begin
                            exp_sel[s] = 2'd2;
                            exp_stall  = 1'b1;
                        end else begin
                            exp_sel[s]  = 2'd1;
                            exp_data[s] = stage_result[i*WIDTH +: WIDTH];
                        end
                        break;
                    end
                end
            end
            check($sformatf("sel%0d", s), 64'(fwd_sel[s*2 +: 2]), 64'(exp_sel[s]));
            if (exp_sel[s] != 2'd2)
                check($sformatf("data%0d", s), 64'(src_data[s*WIDTH +: WIDTH]), 64'(exp_data[s]));
        end
        check("stall", 64'(hazard_stall), 64'(exp_stall));
    endtask

    task automatic eval();
        @(negedge clock);
        compare();
    endtask

    // Clock edge: update the model exactly as the pipeline rules describe.
    task automatic tick();
        slot_t n;
        @(posedge clock);
        if (!reset) begin
            q.delete();
        end else if (advance) begin
            n.v  = issue_valid && issue_we && (issue_rd != 0) && !flush && !exp_stall;
            n.rd = int'(issue_rd);
            n.ld = issue_is_load;
            q.push_front(n);
            if (q.size() > DEPTH) void'(q.pop_back());
        end
        #1;
    endtask

    task automatic idle();
        advance = 1'b1; flush = 1'b0; issue_valid = 1'b0; issue_we = 1'b0;
        issue_is_load = 1'b0; issue_rd = '0; src_used = '0; src_reg = '0;
        stage_result = {32'h3333_0003, 32'h2222_0002, 32'h1111_0001};
        src_rf_data = {32'hF1F1_0001, 32'hF0F0_0000};
    endtask

    task automatic issue(input int rd, input bit ld);
        issue_valid = 1'b1; issue_we = 1'b1; issue_rd = REG_BITS'(rd); issue_is_load = ld;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        q.delete();
        idle();
        eval(); tick();
        reset = 1'b1;
    endtask

    task automatic drop_reset_now();
        reset = 1'b0;
        #1;
        q.delete();
        compare();
    endtask

    initial begin
        idle();
        // Reset state: outputs pass RF data through.
        src_used = 2'b11; src_reg = {5'd3, 5'd5};
        eval();
        check("rst_stall", 64'(hazard_stall), 64'd0);
        check("rst_sel", 64'(fwd_sel), 64'd0);
        tick();
        reset = 1'b1;

        // 1: ALU result forwarded from X.
        idle(); issue(3, 0); eval(); tick();
        idle(); src_used = 2'b01; src_reg = {5'd0, 5'd3};
        stage_result[31:0] = 32'h1234;
        eval();
        check("t1_data", 64'(src_data[31:0]), 64'h1234);
        check("t1_sel", 64'(fwd_sel[1:0]), 64'd1);
        tick();

        // 2: load-use stalls one cycle, then forwards from M.
        do_reset();
        idle(); issue(5, 1); eval(); tick();
        idle(); issue_valid = 1'b1; src_used = 2'b01; src_reg = {5'd0, 5'd5};
        eval();
        check("t2_stall", 64'(hazard_stall), 64'd1);
        check("t2_sel", 64'(fwd_sel[1:0]), 64'd2);
        tick();
        stage_result[63:32] = 32'hBEEF;
        eval();
        check("t2_stall_after", 64'(hazard_stall), 64'd0);
        check("t2_data", 64'(src_data[31:0]), 64'hBEEF);
        tick();
`ifdef BYPASS_STATS_EN
        idle(); eval();
        check("t6_stall_cnt", 64'(stat_stall_cnt), 64'd1);
        check("t6_fwd_cnt", 64'(stat_fwd_cnt), 64'd1);
        tick();
`endif

        // 3: youngest of two producers wins; r0 reads never forward.
        do_reset();
        idle(); issue(7, 0); eval(); tick();
        idle(); issue(1, 0); eval(); tick();
        idle(); issue(7, 0); eval(); tick();
        idle(); src_used = 2'b11; src_reg = {5'd0, 5'd7};
        stage_result = {32'hC, 32'hB, 32'hA};
        src_rf_data = {32'h0, 32'h5555};
        eval();
        check("t3_data0", 64'(src_data[31:0]), 64'hA);
        check("t3_data1", 64'(src_data[63:32]), 64'h0);
        check("t3_sel1", 64'(fwd_sel[3:2]), 64'd0);
        tick();

        // 4: rd=0 never tracked; flushed issue never tracked.
        do_reset();
        idle(); issue(0, 0); eval(); tick();
        idle(); issue(9, 0); flush = 1'b1; eval(); tick();
        for (int k = 0; k < 3; k++) begin
            idle(); src_used = 2'b11; src_reg = {5'd9, 5'd0};
            eval();
            check("t4_sel", 64'(fwd_sel), 64'd0);
            check("t4_data1", 64'(src_data[63:32]), 64'hF1F1_0001);
            tick();
        end

        // 5: global hold keeps the stall; async reset clears it at once.
        do_reset();
        idle(); issue(5, 1); eval(); tick();
        for (int k = 0; k < 3; k++) begin
            idle(); advance = 1'b0; issue(6, 0); src_used = 2'b10; src_reg = {5'd5, 5'd0};
            eval();
            check("t5_hold_stall", 64'(hazard_stall), 64'd1);
            tick();
        end
        drop_reset_now();
        check("t5_rst_stall", 64'(hazard_stall), 64'd0);
        check("t5_rst_sel", 64'(fwd_sel), 64'd0);
        eval(); tick();
        reset = 1'b1;

`ifdef BYPASS_STATS_EN
        // 6: stall counter saturates.
        do_reset();
        idle(); issue(5, 1); eval(); tick();
        idle(); advance = 1'b0; src_used = 2'b01; src_reg = {5'd0, 5'd5};
        repeat (70000) @(posedge clock);
        #1;
        check("t6_stall_sat", 64'(stat_stall_cnt), 64'hFFFF);
        eval(); tick();
`endif

        // Randomized traffic against the model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 199) == 0) drop_reset_now();
            else if (!reset && $urandom_range(0, 3) == 0) reset = 1'b1;
            advance       = ($urandom_range(0, 9) != 0);
            flush         = ($urandom_range(0, 9) == 0);
            issue_valid   = ($urandom_range(0, 7) != 0);
            issue_we      = ($urandom_range(0, 4) != 0);
            issue_is_load = ($urandom_range(0, 2) == 0);
            issue_rd      = REG_BITS'($urandom_range(0, 4));
            stage_result  = {$urandom, $urandom, $urandom};
            src_used      = NUM_SRC'($urandom);
            src_reg       = {REG_BITS'($urandom_range(0, 4)), REG_BITS'($urandom_range(0, 4))};
            src_rf_data   = {$urandom, $urandom};
            eval();
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
